// File: rtl/pid_pwm_out.sv
// Sign-magnitude PWM output stage for the PID controller: per-channel shadow command capture,
// period-aligned magnitude updates and a dead-time interval on every direction reversal.
module pid_pwm_out #(
    parameter int aw       = 1,
    parameter int an       = 1 << aw,
    parameter int ow       = 12,
    parameter int deadtime = 64
) (
    input  logic          clk_pid,
    input  logic          reset,
    // ce is a valid-only strobe: there is no ready, the addressed shadow register
    // accepts m_k on every rising edge where ce=1, and a later write overwrites an earlier one.
    input  logic          ce,
    input  logic [aw-1:0] a,
    input  logic [ow-1:0] m_k,
    input  logic          enable,
    output logic [an-1:0] pwm,
    output logic [an-1:0] dir,
    output logic          period_start,
    output logic [an-1:0] dead_state
);

    localparam int cw = ow - 1;

    localparam logic [0:0] st_run  = 1'b0;
    localparam logic [0:0] st_dead = 1'b1;

    localparam logic [cw-1:0] dead_load = cw'(deadtime);
    localparam logic [cw-1:0] mag_max   = '1;

    logic [cw-1:0] cnt;
    logic          boundary;

    logic [ow-1:0] shadow   [an];
    logic [ow-1:0] abs_cmd  [an];
    logic [cw-1:0] req_mag  [an];
    logic [an-1:0] req_sign;

    logic [cw-1:0] mag      [an];
    logic [0:0]    state    [an];
    logic [cw-1:0] dcnt     [an];

    // Boundary event: the edge on which cnt wraps back to zero.
    assign boundary = &cnt;

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + cw'(1);
            period_start <= boundary;
        end
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < an; i++) begin
                if (ce && (a == aw'(i))) begin
                    shadow[i] <= m_k;
                end
            end
        end
    end

    // The most negative command has no positive counterpart in ow bits; clamp it to full scale.
    always_comb begin
        for (int i = 0; i < an; i++) begin
            req_sign[i] = shadow[i][ow-1];
            abs_cmd[i]  = req_sign[i] ? (~shadow[i] + ow'(1)) : shadow[i];
            req_mag[i]  = abs_cmd[i][ow-1] ? mag_max : abs_cmd[i][cw-1:0];
        end
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            dir <= '0;
            for (int i = 0; i < an; i++) begin
                mag[i]   <= '0;
                state[i] <= st_run;
                dcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < an; i++) begin
                case (state[i])
                    st_run: begin
                        if (boundary) begin
                            if (req_mag[i] == '0) begin
                                mag[i] <= '0;
                            end else if (req_sign[i] == dir[i]) begin
                                mag[i] <= req_mag[i];
                            end else begin
                                mag[i]   <= '0;
                                dcnt[i]  <= dead_load;
                                state[i] <= st_dead;
                            end
                        end
                    end
                    st_dead: begin
                        // Direction flips only once the full dead interval has elapsed.
                        if (dcnt[i] == cw'(1)) begin
                            dir[i]   <= ~dir[i];
                            dcnt[i]  <= '0;
                            state[i] <= st_run;
                        end else begin
                            dcnt[i] <= dcnt[i] - cw'(1);
                        end
                    end
                    default: begin
                        state[i] <= st_run;
                        dcnt[i]  <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < an; i++) begin
                pwm[i] <= enable && (state[i] == st_run) && (cnt < mag[i]);
            end
        end
    end

    always_comb begin
        dead_state = '0;
        for (int i = 0; i < an; i++) begin
            dead_state[i] = (state[i] == st_dead);
        end
    end

endmodule
